// File: rtl/aes_mixcolumns_iter.sv
// Iterative AES MixColumns / InvMixColumns over a full 128-bit state.
// COLS_PER_CYCLE columns are transformed in place per BUSY cycle.
module aes_mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inv,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("aes_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // col_idx advances by this step and wraps mod 4, so a full-width step of 4 is 0.
    localparam logic [1:0] COL_STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL_IDX = 2'(4 - COLS_PER_CYCLE);

    logic [1:0]   state_q, state_d;
    logic [1:0]   col_idx_q, col_idx_d;
    logic         inv_q, inv_d;
    logic [127:0] data_q, data_d;
    logic [127:0] busy_next;
    logic [1:0]   col_sel;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // Forward uses {02,03,01,01}, inverse {0e,0b,0d,09}; both rotate per output row.
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inv);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [7:0]  fwd_b;
        logic [7:0]  inv_b;
        logic [1:0]  i1, i2, i3;
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            a[i]  = col[31-8*i -: 8];
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int i = 0; i < 4; i++) begin
            i1    = 2'(i + 1);
            i2    = 2'(i + 2);
            i3    = 2'(i + 3);
            fwd_b = x2[i] ^ (x2[i1] ^ a[i1]) ^ a[i2] ^ a[i3];
            inv_b = (x8[i] ^ x4[i] ^ x2[i])
                  ^ (x8[i1] ^ x2[i1] ^ a[i1])
                  ^ (x8[i2] ^ x4[i2] ^ a[i2])
                  ^ (x8[i3] ^ a[i3]);
            res[31-8*i -: 8] = inv ? inv_b : fwd_b;
        end
        return res;
    endfunction

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        busy_next = data_q;
        col_sel   = col_idx_q;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_sel = col_idx_q + 2'(k);
            busy_next[127-32*int'(col_sel) -: 32] =
                mix_column(data_q[127-32*int'(col_sel) -: 32], inv_q);
        end
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        inv_d     = inv_q;
        data_d    = data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d    = in_state;
                    inv_d     = in_inv;
                    col_idx_d = '0;
                    state_d   = ST_BUSY;
                end
            end
            ST_BUSY: begin
                data_d    = busy_next;
                col_idx_d = col_idx_q + COL_STEP;
                if (col_idx_q == LAST_COL_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the working register is reset too, so out_state reads zero straight after reset
    // and an aborted transaction leaves nothing behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            state_q   <= ST_IDLE;
            col_idx_q <= '0;
            inv_q     <= 1'b0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            inv_q     <= inv_d;
            data_q    <= data_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign out_state = data_q;

endmodule

// File: tb/tb_aes_mixcolumns_iter.sv
// Scoreboard bench for aes_mixcolumns_iter: main instance at COLS_PER_CYCLE=1,
// plus 2- and 4-column instances exercised on the FIPS-197 vector for latency.
module tb_aes_mixcolumns_iter;

    localparam logic [127:0] FWD_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] FWD_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] INV_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] INV_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

    logic         clk;
    logic         rst;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready;
    logic [127:0] in_state, out_state;

    logic         s_in_valid  [2];
    logic         s_in_ready  [2];
    logic         s_in_inv    [2];
    logic         s_out_valid [2];
    logic         s_out_ready [2];
    logic [127:0] s_in_state  [2];
    logic [127:0] s_out_state [2];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int n_sent    = 0;
    int n_recv    = 0;
    logic rdy_rand = 1'b0;
    logic rdy_hold = 1'b1;
    logic [127:0] exp_q [$];

    aes_mixcolumns_iter #(.COLS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_inv(in_inv), .in_state(in_state),
        .out_valid(out_valid), .out_ready(out_ready), .out_state(out_state)
    );

    aes_mixcolumns_iter #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid[0]), .in_ready(s_in_ready[0]), .in_inv(s_in_inv[0]),
        .in_state(s_in_state[0]), .out_valid(s_out_valid[0]), .out_ready(s_out_ready[0]),
        .out_state(s_out_state[0])
    );

    aes_mixcolumns_iter #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(s_in_valid[1]), .in_ready(s_in_ready[1]), .in_inv(s_in_inv[1]),
        .in_state(s_in_state[1]), .out_valid(s_out_valid[1]), .out_ready(s_out_ready[1]),
        .out_state(s_out_state[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // GF(2^8) multiply by shift-and-add, reduced by the AES polynomial 0x11b.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int p  = 0;
        int aa = int'(a);
        int bb = int'(b);
        for (int i = 0; i < 8; i++) begin
            if ((bb & 1) != 0) p = p ^ aa;
            aa = aa << 1;
            if ((aa & 'h100) != 0) aa = aa ^ 'h11b;
            bb = bb >> 1;
        end
        return p[7:0];
    endfunction

    // Matrix-times-column over each of the four columns.
    function automatic logic [127:0] ref_mix(input logic [127:0] st, input logic inv);
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] res;
        res = '0;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - r + 4) % 4], st[127-32*c-8*j -: 8]);
                res[127-32*c-8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    // Caller is off-edge; returns at accept edge + 1.
    task automatic send(input logic [127:0] st, input logic inv, input logic [127:0] exp);
        int n = 0;
        in_state = st;
        in_inv   = inv;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(exp);
        n_sent++;
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain");
    endtask

    task automatic small_fips(input int k, input int cols);
        int cnt = 0;
        @(posedge clk);
        #1;
        s_in_state[k]  = FWD_IN;
        s_in_inv[k]    = 1'b0;
        s_in_valid[k]  = 1'b1;
        s_out_ready[k] = 1'b0;
        @(negedge clk);
        check($sformatf("c%0d_in_ready_idle", cols), s_in_ready[k], 1);
        @(posedge clk);
        #1 s_in_valid[k] = 1'b0;
        s_in_state[k] = '0;
        while (cnt < 20) begin
            @(negedge clk);
            if (s_out_valid[k]) break;
            @(posedge clk);
            cnt++;
        end
        check($sformatf("c%0d_latency", cols), cnt, 4 / cols);
        check($sformatf("c%0d_fwd_value", cols), s_out_state[k], FWD_OUT);
        s_out_ready[k] = 1'b1;
        @(posedge clk);
        #1 s_out_ready[k] = 1'b0;
        @(negedge clk);
        check($sformatf("c%0d_out_valid_release", cols), s_out_valid[k], 0);
        check($sformatf("c%0d_in_ready_release", cols), s_in_ready[k], 1);
    endtask

    // out_ready driver: held value or random stalls.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
            else          out_ready = rdy_hold;
        end
    end

    // Monitor: compares every handshaken output against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) fail_now("unexpected_output");
                else check("out_state", out_state, exp_q.pop_front());
                n_recv++;
            end
        end
    end

    initial begin
        int cnt;
        logic [127:0] exp_v;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_inv   = 1'b0;
        in_state = '0;
        for (int k = 0; k < 2; k++) begin
            s_in_valid[k]  = 1'b0;
            s_in_inv[k]    = 1'b0;
            s_in_state[k]  = '0;
            s_out_ready[k] = 1'b0;
        end
        #12;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_state", out_state, '0);
        check("rst_c4_out_state", s_out_state[1], '0);
        @(negedge clk);
        rst = 1'b0;

        // Forward FIPS-197 vector with latency on the 1-column instance.
        @(posedge clk);
        #1;
        send(FWD_IN, 1'b0, FWD_OUT);
        cnt = 0;
        while (cnt < 20) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            cnt++;
        end
        check("c1_latency", cnt, 4);
        drain();
        small_fips(0, 2);
        small_fips(1, 4);

        // Inverse vector.
        @(posedge clk);
        #1;
        send(INV_IN, 1'b1, INV_OUT);
        drain();

        // Backpressure: 10 stalled cycles, then release.
        @(negedge clk);
        rdy_hold = 1'b0;
        @(posedge clk);
        #1;
        exp_v = {$urandom, $urandom, $urandom, $urandom};
        send(exp_v, 1'b0, ref_mix(exp_v, 1'b0));
        exp_v = ref_mix(exp_v, 1'b0);
        cnt = 0;
        @(negedge clk);
        while (!out_valid && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        for (int i = 0; i < 10; i++) begin
            check("stall_out_state", out_state, exp_v);
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            @(negedge clk);
        end
        rdy_hold = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("release_out_valid", out_valid, 0);
        check("release_in_ready", in_ready, 1);
        drain();

        // Mode latch: inputs churn (with in_valid high) through every BUSY cycle.
        @(posedge clk);
        #1;
        send(INV_IN, 1'b1, INV_OUT);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_inv   = i[0];
            in_state = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        drain();

        // Async reset two cycles into BUSY, asserted off-edge.
        @(posedge clk);
        #1;
        send(FWD_IN, 1'b0, FWD_OUT);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_state", out_state, '0);
        exp_q.delete();
        n_sent--;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        send(FWD_IN, 1'b0, FWD_OUT);
        drain();

        // Randomised back-to-back traffic with random output stalls.
        rdy_rand = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            logic [127:0] st;
            logic         iv;
            st = {$urandom, $urandom, $urandom, $urandom};
            iv = 1'($urandom_range(0, 1));
            send(st, iv, ref_mix(st, iv));
        end
        drain();
        rdy_rand = 1'b0;
        repeat (3) @(negedge clk);
        check("txn_count", n_recv, n_sent);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
